// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: holds a grant for up to weight[i] acknowledged beats,
// then rotates to the next requester without an idle cycle between grants.
module weighted_rr_arbiter #(
  parameter int    PORTS        = 4,
  parameter int    WEIGHT_WIDTH = 4,
  parameter string LSB_PRIORITY = "LOW"
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS-1:0]              request,
  input  logic [PORTS-1:0]              acknowledge,
  input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
  output logic [PORTS-1:0]              grant,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_encoded,
  output logic                          grant_last
);

  localparam int               IDX_W     = $clog2(PORTS);
  localparam bit               DESCEND   = (LSB_PRIORITY == "HIGH");
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PORTS - 1);
  localparam logic [IDX_W-1:0] PTR_RESET = DESCEND ? LAST_IDX : '0;
  localparam logic [IDX_W:0]   PORTS_W   = (IDX_W+1)'(PORTS);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                  state_reg;
  logic [PORTS-1:0]        grant_reg;
  logic                    grant_valid_reg;
  logic [IDX_W-1:0]        grant_encoded_reg;
  logic [WEIGHT_WIDTH-1:0] credit_reg;
  logic [IDX_W-1:0]        ptr_reg;

  // Fresh credit per port; a zero weight still buys one beat.
  logic [WEIGHT_WIDTH-1:0] credit_load [PORTS];
  // order_idx[k] is the port visited k-th by the search that starts at ptr_reg.
  logic [IDX_W-1:0]        order_idx [PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_port
      logic [WEIGHT_WIDTH-1:0] weight_slice;
      logic [IDX_W:0]          order_sum;

      assign weight_slice    = weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      assign credit_load[gi] = (weight_slice == '0) ? WEIGHT_WIDTH'(1) : weight_slice;

      if (DESCEND) begin : g_desc
        assign order_sum = {1'b0, ptr_reg} + (IDX_W+1)'(PORTS - gi);
      end else begin : g_asc
        assign order_sum = {1'b0, ptr_reg} + (IDX_W+1)'(gi);
      end

      assign order_idx[gi] = (order_sum >= PORTS_W) ? IDX_W'(order_sum - PORTS_W)
                                                    : order_sum[IDX_W-1:0];
    end
  endgenerate

  logic             beat;
  logic             own_request;
  logic             release_done;
  logic             release_drop;
  logic             release_any;
  logic [PORTS-1:0] eligible;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] win_ptr_next;
  logic [PORTS-1:0] win_onehot;
  logic             take_grant;

  assign beat         = grant_valid_reg & |(acknowledge & grant_reg);
  assign own_request  = |(request & grant_reg);
  assign release_done = beat & (credit_reg == WEIGHT_WIDTH'(1));
  assign release_drop = ~own_request & ~beat;
  assign release_any  = (state_reg == GRANT) & (release_done | release_drop);

  // A port that walked away from its grant is not a candidate for the follow-on grant.
  assign eligible = ((state_reg == GRANT) && release_drop) ? (request & ~grant_reg) : request;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      if (eligible[order_idx[k]]) begin
        win_found = 1'b1;
        win_idx   = order_idx[k];
      end
    end
  end

  always_comb begin
    win_ptr_next = '0;
    if (DESCEND) begin
      win_ptr_next = (win_idx == '0) ? LAST_IDX : win_idx - IDX_W'(1);
    end else begin
      win_ptr_next = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
    end
  end

  assign win_onehot = PORTS'(1) << win_idx;
  assign take_grant = win_found & ((state_reg == IDLE) | release_any);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      grant_reg         <= '0;
      grant_valid_reg   <= 1'b0;
      grant_encoded_reg <= '0;
      credit_reg        <= '0;
      ptr_reg           <= PTR_RESET;
    end else begin
      case (state_reg)
        IDLE: begin
          if (take_grant) begin
            state_reg         <= GRANT;
            grant_reg         <= win_onehot;
            grant_valid_reg   <= 1'b1;
            grant_encoded_reg <= win_idx;
            credit_reg        <= credit_load[win_idx];
            ptr_reg           <= win_ptr_next;
          end
        end
        GRANT: begin
          if (take_grant) begin
            grant_reg         <= win_onehot;
            grant_valid_reg   <= 1'b1;
            grant_encoded_reg <= win_idx;
            credit_reg        <= credit_load[win_idx];
            ptr_reg           <= win_ptr_next;
          end else if (release_any) begin
            // Nobody left to serve: drop the grant but keep the last index visible.
            state_reg       <= IDLE;
            grant_reg       <= '0;
            grant_valid_reg <= 1'b0;
            credit_reg      <= '0;
          end else if (beat) begin
            credit_reg <= credit_reg - WEIGHT_WIDTH'(1);
          end
        end
        default: begin
          state_reg       <= IDLE;
          grant_reg       <= '0;
          grant_valid_reg <= 1'b0;
          credit_reg      <= '0;
        end
      endcase
    end
  end

  assign grant         = grant_reg;
  assign grant_valid   = grant_valid_reg;
  assign grant_encoded = grant_encoded_reg;
  assign grant_last    = grant_valid_reg & (credit_reg == WEIGHT_WIDTH'(1));

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Bench for weighted_rr_arbiter: LOW and HIGH priority instances share stimulus and are
// checked every cycle against a port-walking reference model plus directed expectations.
module tb_weighted_rr_arbiter;

  localparam int P  = 4;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [P-1:0]  request = '0;
  logic [P-1:0]  acknowledge = '0;
  logic [P*WW-1:0] weight = '0;

  logic [P-1:0]  grant_l, grant_h;
  logic          valid_l, valid_h, last_l, last_h;
  logic [1:0]    enc_l, enc_h;
  logic [7:0]    obs_l, obs_h;

  int checks = 0;
  int fails  = 0;

  // Reference model state, index 0 = LOW instance, 1 = HIGH instance.
  int m_act  [2];
  int m_g    [2];
  int m_cred [2];
  int m_last [2];
  int m_enc  [2];

  always #5 clk = ~clk;

  weighted_rr_arbiter #(.PORTS(P), .WEIGHT_WIDTH(WW), .LSB_PRIORITY("LOW")) dut_low (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge), .weight(weight),
    .grant(grant_l), .grant_valid(valid_l), .grant_encoded(enc_l), .grant_last(last_l)
  );

  weighted_rr_arbiter #(.PORTS(P), .WEIGHT_WIDTH(WW), .LSB_PRIORITY("HIGH")) dut_high (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge), .weight(weight),
    .grant(grant_h), .grant_valid(valid_h), .grant_encoded(enc_h), .grant_last(last_h)
  );

  assign obs_l = {grant_l, valid_l, enc_l, last_l};
  assign obs_h = {grant_h, valid_h, enc_h, last_h};

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d]  = 0;
      m_g[d]    = 0;
      m_cred[d] = 0;
      m_enc[d]  = 0;
    end
    // "last granted" chosen so the first search lands on the top-priority end
    m_last[0] = P - 1;
    m_last[1] = 0;
  endfunction

  // Walk ports starting after the last granted one; the last granted is visited last.
  function automatic int pick(int d, logic [P-1:0] elig);
    int p;
    for (int n = 1; n <= P; n++) begin
      if (d == 0) p = (m_last[d] + n) % P;
      else        p = (m_last[d] - n + 2 * P) % P;
      if (elig[p]) return p;
    end
    return -1;
  endfunction

  function automatic void model_grant(int d, int p);
    int w;
    w = int'(weight[p*WW +: WW]);
    m_act[d]  = 1;
    m_g[d]    = p;
    m_last[d] = p;
    m_enc[d]  = p;
    m_cred[d] = (w == 0) ? 1 : w;
  endfunction

  function automatic void model_settle(int d, int p);
    if (p >= 0) model_grant(d, p);
    else begin
      m_act[d]  = 0;
      m_cred[d] = 0;
    end
  endfunction

  function automatic void model_step(int d);
    logic [P-1:0] elig;
    bit beat;
    beat = (m_act[d] != 0) && acknowledge[m_g[d]];
    if (m_act[d] == 0) begin
      if (pick(d, request) >= 0) model_grant(d, pick(d, request));
    end else if (beat && m_cred[d] == 1) begin
      model_settle(d, pick(d, request));
    end else if (beat) begin
      m_cred[d] = m_cred[d] - 1;
    end else if (!request[m_g[d]]) begin
      elig = request;
      elig[m_g[d]] = 1'b0;
      model_settle(d, pick(d, elig));
    end
  endfunction

  function automatic logic [7:0] exp_vec(int d);
    logic [3:0] g;
    logic       a;
    a = (m_act[d] != 0);
    g = a ? 4'(1 << m_g[d]) : 4'b0000;
    return {g, a, 2'(m_enc[d]), a && (m_cred[d] == 1)};
  endfunction

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    request     = '0;
    acknowledge = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    request = '0;
    acknowledge = '0;
    @(posedge clk); #1;
    checks++;
    if (obs_l !== 8'h00) begin fails++; $display("FAIL reset_low got %b want %b", obs_l, 8'h00); end
    checks++;
    if (obs_h !== 8'h00) begin fails++; $display("FAIL reset_high got %b want %b", obs_h, 8'h00); end
    model_reset();
    rst_n = 1'b1;
    cycle();
    checks++;
    if (obs_l !== 8'h00) begin fails++; $display("FAIL reset_idle_low got %b want %b", obs_l, 8'h00); end
    $display("reset: grant_l=%b grant_h=%b", grant_l, grant_h);
  endtask

  task automatic test_burst_regrant();
    logic [3:0] exp_last;
    exp_last = 4'b0100;  // bit c = grant_last after edge c (c=0..3)
    do_reset();
    request = 4'b0100; acknowledge = 4'b0100; weight = 16'h0300;
    for (int c = 0; c < 7; c++) begin
      cycle();
      $display("burst cyc %0d: grant=%b last=%b", c, grant_l, last_l);
      checks++;
      if (obs_l !== exp_vec(0)) begin fails++; $display("FAIL burst_model_low cyc %0d got %b want %b", c, obs_l, exp_vec(0)); end
      checks++;
      if (obs_h !== exp_vec(1)) begin fails++; $display("FAIL burst_model_high cyc %0d got %b want %b", c, obs_h, exp_vec(1)); end
      if (c < 4) begin
        checks++;
        if (grant_l !== 4'b0100 || last_l !== exp_last[c])
          begin fails++; $display("FAIL burst_regrant cyc %0d got grant %b last %b want 0100 %b", c, grant_l, last_l, exp_last[c]); end
      end
    end
  endtask

  task automatic test_all_weight_one();
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    request = 4'b1111; acknowledge = 4'b1111; weight = 16'h1111;
    for (int c = 0; c < 5; c++) begin
      cycle();
      $display("rotate cyc %0d: grant_l=%b", c, grant_l);
      checks++;
      if (grant_l !== seq[c]) begin fails++; $display("FAIL rotate_low cyc %0d got %b want %b", c, grant_l, seq[c]); end
      checks++;
      if (obs_l !== exp_vec(0)) begin fails++; $display("FAIL rotate_model_low cyc %0d got %b want %b", c, obs_l, exp_vec(0)); end
    end
  endtask

  task automatic test_weighted_mix();
    logic [1:0] seq [14];
    seq = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    request = 4'b1111; acknowledge = 4'b1111; weight = 16'h3102;
    for (int c = 0; c < 14; c++) begin
      cycle();
      $display("mix cyc %0d: enc_l=%0d last_l=%b", c, enc_l, last_l);
      checks++;
      if (enc_l !== seq[c] || valid_l !== 1'b1)
        begin fails++; $display("FAIL mix_sequence cyc %0d got enc %0d valid %b want %0d 1", c, enc_l, valid_l, seq[c]); end
      checks++;
      if (obs_l !== exp_vec(0)) begin fails++; $display("FAIL mix_model_low cyc %0d got %b want %b", c, obs_l, exp_vec(0)); end
      checks++;
      if (obs_h !== exp_vec(1)) begin fails++; $display("FAIL mix_model_high cyc %0d got %b want %b", c, obs_h, exp_vec(1)); end
    end
  endtask

  task automatic test_request_drop();
    do_reset();
    request = 4'b0010; acknowledge = 4'b0010; weight = 16'h2050;
    for (int c = 0; c < 3; c++) cycle();  // grant p1 then two beats: 3 credits remain
    request = 4'b1001; acknowledge = 4'b0000;
    cycle();
    $display("drop: grant_l=%b enc_l=%0d last_l=%b", grant_l, enc_l, last_l);
    checks++;
    if (obs_l !== {4'b1000, 1'b1, 2'd3, 1'b0}) begin fails++; $display("FAIL drop_regrant got %b want %b", obs_l, {4'b1000, 1'b1, 2'd3, 1'b0}); end
    checks++;
    if (obs_h !== exp_vec(1)) begin fails++; $display("FAIL drop_model_high got %b want %b", obs_h, exp_vec(1)); end
    request = 4'b0000;
    cycle();
    $display("drop idle: grant_l=%b enc_l=%0d", grant_l, enc_l);
    checks++;
    if (obs_l !== {4'b0000, 1'b0, 2'd3, 1'b0}) begin fails++; $display("FAIL idle_hold_enc got %b want %b", obs_l, {4'b0000, 1'b0, 2'd3, 1'b0}); end
    checks++;
    if (obs_h !== exp_vec(1)) begin fails++; $display("FAIL idle_model_high got %b want %b", obs_h, exp_vec(1)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    request = 4'b0001; acknowledge = 4'b0001; weight = 16'h0004;
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    $display("async reset: grant_l=%b valid_l=%b", grant_l, valid_l);
    checks++;
    if (obs_l !== 8'h00) begin fails++; $display("FAIL async_reset_low got %b want %b", obs_l, 8'h00); end
    checks++;
    if (obs_h !== 8'h00) begin fails++; $display("FAIL async_reset_high got %b want %b", obs_h, 8'h00); end
    model_reset();
    request = 4'b0110; acknowledge = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
    $display("after reset: grant_l=%b grant_h=%b", grant_l, grant_h);
    checks++;
    if (grant_l !== 4'b0010) begin fails++; $display("FAIL ptr_restart_low got %b want %b", grant_l, 4'b0010); end
    checks++;
    if (grant_h !== 4'b0100) begin fails++; $display("FAIL ptr_restart_high got %b want %b", grant_h, 4'b0100); end
  endtask

  task automatic test_high_priority();
    logic [3:0] seq [5];
    seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    do_reset();
    request = 4'b1111; acknowledge = 4'b1111; weight = 16'h1111;
    for (int c = 0; c < 5; c++) begin
      cycle();
      $display("high cyc %0d: grant_h=%b", c, grant_h);
      checks++;
      if (grant_h !== seq[c]) begin fails++; $display("FAIL high_rotate cyc %0d got %b want %b", c, grant_h, seq[c]); end
      checks++;
      if (obs_h !== exp_vec(1)) begin fails++; $display("FAIL high_model cyc %0d got %b want %b", c, obs_h, exp_vec(1)); end
    end
  endtask

  task automatic test_weight_sampled();
    logic [3:0] exp_last;
    exp_last = 4'b1100;
    do_reset();
    request = 4'b0001; acknowledge = 4'b0000; weight = 16'h0003;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (c == 0) begin weight = 16'h1111; acknowledge = 4'b0001; end
      $display("sampled cyc %0d: grant_l=%b last_l=%b", c, grant_l, last_l);
      checks++;
      if (last_l !== exp_last[c] || grant_l !== 4'b0001)
        begin fails++; $display("FAIL weight_sampled cyc %0d got last %b grant %b want %b 0001", c, last_l, grant_l, exp_last[c]); end
      checks++;
      if (obs_l !== exp_vec(0)) begin fails++; $display("FAIL sampled_model_low cyc %0d got %b want %b", c, obs_l, exp_vec(0)); end
    end
  endtask

  task automatic test_random();
    logic [P-1:0] prev_grant;
    do_reset();
    weight = 16'($urandom);
    prev_grant = '0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) request = 4'($urandom);
      if ($urandom_range(0, 15) == 0) weight = 16'($urandom);
      acknowledge = ($urandom_range(0, 1) == 1) ? 4'b1111 : 4'($urandom);
      cycle();
      if (grant_l !== prev_grant) $display("rand cyc %0d: req=%b grant_l=%b grant_h=%b", c, request, grant_l, grant_h);
      prev_grant = grant_l;
      checks++;
      if (obs_l !== exp_vec(0)) begin fails++; $display("FAIL rand_model_low cyc %0d got %b want %b", c, obs_l, exp_vec(0)); end
      checks++;
      if (obs_h !== exp_vec(1)) begin fails++; $display("FAIL rand_model_high cyc %0d got %b want %b", c, obs_h, exp_vec(1)); end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_burst_regrant();
    test_all_weight_one();
    test_weighted_mix();
    test_request_drop();
    test_async_reset();
    test_high_priority();
    test_weight_sampled();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
